// File: rtl/ram_1c_1r_1w.sv
// rtl/ram_1c_1r_1w.sv - single-clock RAM, one write port, one registered read port
`include "util.vh"

module ram_1c_1r_1w #(
    parameter int Width = 8,
    parameter int Depth = 32
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [`CLOG2(Depth)-1:0]    waddr,
    input  logic [Width-1:0]            wdata,
    input  logic [`CLOG2(Depth)-1:0]    raddr,
    output logic [Width-1:0]            rdata
);

    logic [Width-1:0] mem [Depth];

    // Write port plus one-cycle registered read; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/util.vh
// rtl/util.vh - shared helper macros
`ifndef UTIL_VH
`define UTIL_VH

// Address width for a given count; never narrower than one bit.
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))

`endif

// File: rtl/ring_readout.sv
// rtl/ring_readout.sv - capture ring buffer dumped oldest-to-newest on request
`include "util.vh"

module ring_readout #(
    parameter int Width = 8,
    parameter int Depth = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] din_data,
    input  logic             en,
    input  logic             start,
    output logic             busy,
    output logic [Width-1:0] dout_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last
);

    localparam int AW = `CLOG2(Depth);
    localparam int FW = `CLOG2(Depth + 1);

    localparam logic [1:0] S_CAPTURE = 2'd0;
    localparam logic [1:0] S_PRIME   = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);
    localparam logic [FW-1:0] FullCnt  = FW'(Depth);

    logic [1:0]    state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] wr_addr_inc;
    logic [AW-1:0] post_wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_inc;
    logic [AW-1:0] ram_raddr;
    logic [FW-1:0] fill;
    logic [FW-1:0] post_fill;
    logic [FW-1:0] remain;
    logic          ram_we;
    logic          xfer;

    assign ram_we      = (state == S_CAPTURE) && en;
    assign xfer        = dout_valid && dout_ready;
    assign wr_addr_inc = (wr_addr == LastAddr) ? '0 : wr_addr + AW'(1);
    assign rd_addr_inc = (rd_addr == LastAddr) ? '0 : rd_addr + AW'(1);

    // Look ahead one address on a transfer so the next sample is ready a cycle later;
    // during a stall the address holds and the registered read repeats the same word.
    assign ram_raddr = ((state == S_DRAIN) && xfer) ? rd_addr_inc : rd_addr;

    // Write pointer and fill as they will be after this cycle's capture, so a
    // write coinciding with start is part of the dump.
    always_comb begin
        post_wr_addr = wr_addr;
        post_fill    = fill;
        if (ram_we) begin
            post_wr_addr = wr_addr_inc;
            if (fill != FullCnt) begin
                post_fill = fill + FW'(1);
            end
        end
    end

    ram_1c_1r_1w #(
        .Width (Width),
        .Depth (Depth)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (din_data),
        .raddr (ram_raddr),
        .rdata (dout_data)
    );

    // Capture/prime/drain controller with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CAPTURE;
            wr_addr    <= '0;
            fill       <= '0;
            rd_addr    <= '0;
            remain     <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    wr_addr <= post_wr_addr;
                    fill    <= post_fill;
                    if (start && (post_fill != '0)) begin
                        state   <= S_PRIME;
                        busy    <= 1'b1;
                        remain  <= post_fill;
                        rd_addr <= (post_fill == FullCnt) ? post_wr_addr : '0;
                    end
                end
                S_PRIME: begin
                    state      <= S_DRAIN;
                    dout_valid <= 1'b1;
                    dout_last  <= (remain == FW'(1));
                end
                S_DRAIN: begin
                    if (xfer) begin
                        if (remain == FW'(1)) begin
                            state      <= S_CAPTURE;
                            busy       <= 1'b0;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            fill       <= '0;
                            wr_addr    <= '0;
                            rd_addr    <= '0;
                            remain     <= '0;
                        end else begin
                            rd_addr   <= rd_addr_inc;
                            remain    <= remain - FW'(1);
                            dout_last <= (remain == FW'(2));
                        end
                    end
                end
                default: begin
                    state <= S_CAPTURE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_readout.sv
// tb/tb_ring_readout.sv - self-checking bench for ring_readout
module tb_ring_readout;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_data = '0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       dout_ready = 1'b0;
    logic       busy;
    logic [7:0] dout_data;
    logic       dout_valid;
    logic       dout_last;

    logic [7:0] din5 = '0;
    logic       en5 = 1'b0;
    logic       start5 = 1'b0;
    logic       ready5 = 1'b0;
    logic       busy5;
    logic [7:0] dout5;
    logic       valid5;
    logic       last5;

    int total = 0;
    int bad = 0;
    logic [7:0] model[$];

    always #5 clk = ~clk;

    ring_readout #(.Width(8), .Depth(D)) dut (
        .clk(clk), .rst(rst), .din_data(din_data), .en(en), .start(start),
        .busy(busy), .dout_data(dout_data), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last)
    );

    ring_readout #(.Width(8), .Depth(5)) dut5 (
        .clk(clk), .rst(rst), .din_data(din5), .en(en5), .start(start5),
        .busy(busy5), .dout_data(dout5), .dout_valid(valid5),
        .dout_ready(ready5), .dout_last(last5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ring: keeps only the newest D captured samples.
    task automatic model_push(input logic [7:0] d);
        model.push_back(d);
        if (model.size() > D) void'(model.pop_front());
    endtask

    task automatic cap(input logic [7:0] d);
        en = 1'b1;
        din_data = d;
        tick();
        en = 1'b0;
        model_push(d);
    endtask

    // mode 0: always ready, 1: 3-cycle stall on 3rd sample then alternate, 2: random
    task automatic dump(input int mode, input bit en_with_start, input logic [7:0] d_with,
                        input bit en_in_drain);
        logic [7:0] exp[$];
        int idx;
        int cyc;
        int hold;
        start = 1'b1;
        if (en_with_start) begin
            en = 1'b1;
            din_data = d_with;
            model_push(d_with);
        end
        tick();
        start = 1'b0;
        en = 1'b0;
        exp = model;
        model.delete();
        if (exp.size() == 0) begin
            for (int i = 0; i < 4; i++) begin
                chk("idle_busy", busy, 0);
                chk("idle_valid", dout_valid, 0);
                tick();
            end
            return;
        end
        chk("prime_busy", busy, 1);
        chk("prime_valid", dout_valid, 0);
        tick();
        idx = 0;
        cyc = 0;
        hold = 0;
        while (idx < exp.size() && cyc < 400) begin
            case (mode)
                0: dout_ready = 1'b1;
                1: begin
                    if (idx == 2 && hold < 3) begin
                        dout_ready = 1'b0;
                        hold++;
                    end else if (hold >= 3) begin
                        dout_ready = cyc[0];
                    end else begin
                        dout_ready = 1'b1;
                    end
                end
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            if (en_in_drain) begin
                en = 1'b1;
                din_data = 8'hEE;
            end
            chk("drain_valid", dout_valid, 1);
            chk("drain_busy", busy, 1);
            chk("drain_data", dout_data, exp[idx]);
            chk("drain_last", dout_last, (idx == exp.size() - 1));
            if (dout_ready) idx++;
            cyc++;
            tick();
        end
        en = 1'b0;
        dout_ready = 1'b0;
        chk("drain_count", idx, exp.size());
        if (mode == 0) chk("throughput", cyc, exp.size());
        chk("end_valid", dout_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_last", dout_last, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_busy5", busy5, 0);
        rst = 1'b0;

        // Partial fill, no wrap
        for (int v = 1; v <= 3; v++) cap(8'(v));
        dump(0, 1'b0, 8'h00, 1'b0);

        // Overfill by four: oldest four dropped
        for (int v = 8'h10; v <= 8'h1B; v++) cap(8'(v));
        dump(0, 1'b0, 8'h00, 1'b0);

        // Full ring with stalls, and en held during drain
        for (int v = 8'hA0; v <= 8'hA7; v++) cap(8'(v));
        dump(1, 1'b0, 8'h00, 1'b1);

        // Capture on the start cycle into an empty ring; the drain-time en left nothing behind
        dump(0, 1'b1, 8'h55, 1'b0);

        // Start on an empty ring is ignored
        dump(0, 1'b0, 8'h00, 1'b0);

        // Reset in the 4th drain cycle aborts the dump
        for (int v = 8'h30; v <= 8'h37; v++) cap(8'(v));
        start = 1'b1;
        tick();
        start = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_abort_valid", dout_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dout_ready = 1'b0;
        model.delete();
        chk("abort_valid", dout_valid, 0);
        chk("abort_busy", busy, 0);
        dump(0, 1'b0, 8'h00, 1'b0);

        // Non-power-of-two depth: 0..6 into a 5-deep ring yields 2..6
        for (int v = 0; v <= 6; v++) begin
            en5 = 1'b1;
            din5 = 8'(v);
            tick();
        end
        en5 = 1'b0;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        ready5 = 1'b1;
        chk("d5_prime_busy", busy5, 1);
        chk("d5_prime_valid", valid5, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("d5_valid", valid5, 1);
            chk("d5_data", dout5, k + 2);
            chk("d5_last", last5, (k == 4));
            tick();
        end
        chk("d5_end_valid", valid5, 0);
        chk("d5_end_busy", busy5, 0);
        ready5 = 1'b0;

        // Randomized capture runs dumped under random backpressure
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                else cap(8'($urandom));
            end
            dump(2, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
